// File: rtl/dcache_pkg.sv
// Shared types and sizing for the direct-mapped write-through data cache.
package cache_pkg;

  localparam int INDEX_BITS = 3;
  localparam int TAG_BITS   = 27;
  localparam int LINES      = 8;
  localparam int CNT_W      = 16;
  localparam int WORD_W     = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REFILL = 2'd1,
    WRITE  = 2'd2
  } state_e;

  typedef logic [INDEX_BITS-1:0] index_t;
  typedef logic [TAG_BITS-1:0]   tag_t;
  typedef logic [WORD_W-3:0]     wordAddr_t;

  // Line index from a word address (byte offset already stripped).
  function automatic index_t wordIndex(input wordAddr_t w);
    return w[INDEX_BITS-1:0];
  endfunction

  // Tag from a word address.
  function automatic tag_t wordTag(input wordAddr_t w);
    return w[WORD_W-3:INDEX_BITS];
  endfunction

  // Counter increment that sticks at all-ones.
  function automatic logic [CNT_W-1:0] satInc(input logic [CNT_W-1:0] c);
    return (c == '1) ? c : c + 1'b1;
  endfunction

endpackage

// File: rtl/dcache_if.sv
// CPU-side request bus and memory-side bus of the data cache in one bundle.
interface dcache_if;
  import cache_pkg::*;

  logic              req_valid;
  logic              req_we;
  logic [WORD_W-1:0] addr;
  logic [WORD_W-1:0] wdata;
  logic              flush;
  logic [WORD_W-1:0] rdata;
  logic              stall;
  logic              mem_req;
  logic              mem_we;
  logic [WORD_W-1:0] mem_addr;
  logic [WORD_W-1:0] mem_wdata;
  logic              mem_ready;
  logic [WORD_W-1:0] mem_rdata;
  logic [CNT_W-1:0]  hit_cnt;
  logic [CNT_W-1:0]  miss_cnt;

  // The cache itself.
  modport slave (
    input  req_valid, req_we, addr, wdata, flush, mem_ready, mem_rdata,
    output rdata, stall, mem_req, mem_we, mem_addr, mem_wdata, hit_cnt, miss_cnt
  );

  // The CPU plus memory environment around the cache.
  modport master (
    output req_valid, req_we, addr, wdata, flush, mem_ready, mem_rdata,
    input  rdata, stall, mem_req, mem_we, mem_addr, mem_wdata, hit_cnt, miss_cnt
  );

endinterface

// File: rtl/dcache_array.sv
// Valid/tag/data storage: one write port, combinational read, valid cleared by flush or reset.
module dcache_array
  import cache_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush_i,
  input  logic              we_i,
  input  index_t            idx_i,
  input  tag_t              tag_i,
  input  logic [WORD_W-1:0] wdata_i,
  output logic              valid_o,
  output tag_t              tag_o,
  output logic [WORD_W-1:0] rdata_o
);

  logic [LINES-1:0]  valid_q, valid_d;
  tag_t              tag_q  [LINES];
  logic [WORD_W-1:0] data_q [LINES];

  // Flush beats a same-edge line fill, so a flushed refill leaves the line invalid.
  always_comb begin
    valid_d = valid_q;
    if (flush_i) begin
      valid_d = '0;
    end else if (we_i) begin
      valid_d[idx_i] = 1'b1;
    end
  end

  // Valid bits are the only storage that reset touches.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
    end else begin
      valid_q <= valid_d;
    end
  end

  // Tag and data are left uninitialised; writes are blocked while reset is held.
  always_ff @(posedge clk) begin
    if (we_i && rst_n) begin
      tag_q[idx_i]  <= tag_i;
      data_q[idx_i] <= wdata_i;
    end
  end

  assign valid_o = valid_q[idx_i];
  assign tag_o   = tag_q[idx_i];
  assign rdata_o = data_q[idx_i];

endmodule

// File: rtl/dcache.sv
// Direct-mapped, write-through, no-write-allocate data cache with load hit/miss counters.
module dcache
  import cache_pkg::*;
(
  input  logic     clk,
  input  logic     rst_n,
  dcache_if.slave  bus
);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  hitCnt_q, hitCnt_d;
  logic [CNT_W-1:0]  missCnt_q, missCnt_d;
  wordAddr_t         wordAddr;
  index_t            reqIdx;
  tag_t              reqTag;
  logic              lineValid;
  tag_t              lineTag;
  logic [WORD_W-1:0] lineData;
  logic              hit;
  logic              arrWe;
  logic [WORD_W-1:0] arrWdata;
  logic              stall;
  logic              memReq;
  logic              memWe;
  logic [WORD_W-1:0] rdata;

  assign wordAddr = bus.addr[WORD_W-1:2];
  assign reqIdx   = wordIndex(wordAddr);
  assign reqTag   = wordTag(wordAddr);
  assign hit      = lineValid && (lineTag == reqTag);

  dcache_array u_array (
    .clk     (clk),
    .rst_n   (rst_n),
    .flush_i (bus.flush),
    .we_i    (arrWe),
    .idx_i   (reqIdx),
    .tag_i   (reqTag),
    .wdata_i (arrWdata),
    .valid_o (lineValid),
    .tag_o   (lineTag),
    .rdata_o (lineData)
  );

  // Next state, line writes, counters and bus outputs; a refilled load finishes as a hit in IDLE.
  always_comb begin
    state_d   = state_q;
    hitCnt_d  = hitCnt_q;
    missCnt_d = missCnt_q;
    stall     = 1'b0;
    memReq    = 1'b0;
    memWe     = 1'b0;
    rdata     = '0;
    arrWe     = 1'b0;
    arrWdata  = bus.wdata;
    unique case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          if (bus.req_we) begin
            stall   = 1'b1;
            arrWe   = hit;
            state_d = WRITE;
          end else if (hit) begin
            rdata    = lineData;
            hitCnt_d = satInc(hitCnt_q);
          end else begin
            stall     = 1'b1;
            missCnt_d = satInc(missCnt_q);
            state_d   = REFILL;
          end
        end
      end
      REFILL: begin
        memReq = 1'b1;
        stall  = 1'b1;
        if (bus.mem_ready) begin
          arrWe    = 1'b1;
          arrWdata = bus.mem_rdata;
          state_d  = IDLE;
        end
      end
      WRITE: begin
        memReq = 1'b1;
        memWe  = 1'b1;
        stall  = !bus.mem_ready;
        if (bus.mem_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Reset aborts any memory transaction at once because memReq decodes the state directly.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      hitCnt_q  <= '0;
      missCnt_q <= '0;
    end else begin
      state_q   <= state_d;
      hitCnt_q  <= hitCnt_d;
      missCnt_q <= missCnt_d;
    end
  end

  assign bus.rdata     = rdata;
  assign bus.stall     = stall;
  assign bus.mem_req   = memReq;
  assign bus.mem_we    = memWe;
  assign bus.mem_addr  = {wordAddr, 2'b00};
  assign bus.mem_wdata = bus.wdata;
  assign bus.hit_cnt   = hitCnt_q;
  assign bus.miss_cnt  = missCnt_q;

endmodule

// File: tb/tb_dcache.sv
// Self-checking bench for dcache: directed scenarios plus random traffic against a cache/memory model.
module tb_dcache;

  logic clk = 1'b0;
  logic rst_n;
  int assertCount = 0;
  int failCount = 0;

  logic [31:0] memArr [logic [29:0]];
  logic        modelValid [8];
  logic [26:0] modelTag [8];
  logic [31:0] modelData [8];
  int          modelHit;
  int          modelMiss;

  dcache_if bus ();

  dcache dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Backing memory: written words remembered, others derived from their address.
  function automatic logic [31:0] memRead(input logic [31:0] a);
    logic [29:0] w;
    w = a[31:2];
    if (memArr.exists(w)) return memArr[w];
    return {w, 2'b01} ^ 32'h5A5A_C3C3;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    assertCount++;
    assert (obs === exp) else begin
      failCount++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic waitCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic resetModel();
    for (int i = 0; i < 8; i++) modelValid[i] = 1'b0;
    modelHit = 0;
    modelMiss = 0;
  endtask

  task automatic flushModel();
    for (int i = 0; i < 8; i++) modelValid[i] = 1'b0;
  endtask

  function automatic int satBump(input int c);
    return (c < 65535) ? c + 1 : c;
  endfunction

  // Drives one request until the cache stops stalling, acting as the memory as well.
  task automatic applyStimulus(input logic we, input logic [31:0] a, input logic [31:0] wd,
                               input int nWait, output int stalls, output logic [31:0] rd,
                               output logic memOk, output logic timedOut);
    int waitCnt;
    logic done;
    waitCnt = 0;
    done = 1'b0;
    stalls = 0;
    rd = 'x;
    memOk = 1'b1;
    timedOut = 1'b1;
    bus.req_valid = 1'b1;
    bus.req_we = we;
    bus.addr = a;
    bus.wdata = wd;
    bus.mem_ready = 1'b0;
    for (int cyc = 0; cyc < 100 && !done; cyc++) begin
      #1;
      if (bus.mem_req === 1'b1) begin
        if (bus.mem_addr !== {a[31:2], 2'b00} || bus.mem_we !== we ||
            (we && bus.mem_wdata !== wd)) memOk = 1'b0;
        if (bus.mem_we === 1'b0) bus.mem_rdata = memRead(bus.mem_addr);
        if (waitCnt == nWait) begin
          bus.mem_ready = 1'b1;
          if (bus.mem_we === 1'b1) memArr[bus.mem_addr[31:2]] = bus.mem_wdata;
        end else begin
          waitCnt++;
        end
      end
      #1;
      if (bus.stall === 1'b0) begin
        rd = bus.rdata;
        timedOut = 1'b0;
        done = 1'b1;
      end else begin
        stalls++;
      end
      waitCycle();
      bus.mem_ready = 1'b0;
    end
    bus.req_valid = 1'b0;
    bus.req_we = 1'b0;
  endtask

  task automatic checkCounters(input string nm);
    checkOutput({nm, "_hitCnt"}, {16'h0, bus.hit_cnt}, modelHit);
    checkOutput({nm, "_missCnt"}, {16'h0, bus.miss_cnt}, modelMiss);
  endtask

  task automatic runLoad(input string nm, input logic [31:0] a, input int nWait);
    logic [2:0] idx;
    logic [26:0] tg;
    logic [31:0] expData, rd;
    int expStalls, stalls;
    logic memOk, timedOut;
    idx = a[4:2];
    tg = a[31:5];
    if (modelValid[idx] && modelTag[idx] == tg) begin
      expStalls = 0;
      expData = modelData[idx];
    end else begin
      expStalls = nWait + 2;
      expData = memRead(a);
      modelValid[idx] = 1'b1;
      modelTag[idx] = tg;
      modelData[idx] = expData;
      modelMiss = satBump(modelMiss);
    end
    modelHit = satBump(modelHit);
    applyStimulus(1'b0, a, 32'h0, nWait, stalls, rd, memOk, timedOut);
    checkOutput({nm, "_timeout"}, {31'h0, timedOut}, 32'h0);
    checkOutput({nm, "_stalls"}, stalls, expStalls);
    checkOutput({nm, "_rdata"}, rd, expData);
    checkOutput({nm, "_memBus"}, {31'h0, memOk}, 32'h1);
    checkCounters(nm);
  endtask

  task automatic runStore(input string nm, input logic [31:0] a, input logic [31:0] wd, input int nWait);
    logic [2:0] idx;
    logic [31:0] rd;
    int stalls;
    logic memOk, timedOut;
    idx = a[4:2];
    if (modelValid[idx] && modelTag[idx] == a[31:5]) modelData[idx] = wd;
    applyStimulus(1'b1, a, wd, nWait, stalls, rd, memOk, timedOut);
    checkOutput({nm, "_timeout"}, {31'h0, timedOut}, 32'h0);
    checkOutput({nm, "_stalls"}, stalls, nWait + 1);
    checkOutput({nm, "_rdata"}, rd, 32'h0);
    checkOutput({nm, "_memBus"}, {31'h0, memOk}, 32'h1);
    checkOutput({nm, "_memWord"}, memRead(a), wd);
    checkCounters(nm);
  endtask

  task automatic pulseFlush();
    bus.flush = 1'b1;
    waitCycle();
    bus.flush = 1'b0;
    flushModel();
  endtask

  initial begin
    logic [26:0] tagPool [3];
    logic [31:0] a;
    int k;
    tagPool[0] = 27'h8;
    tagPool[1] = 27'h9;
    tagPool[2] = 27'h1A3;
    rst_n = 1'b0;
    bus.req_valid = 1'b0;
    bus.req_we = 1'b0;
    bus.addr = '0;
    bus.wdata = '0;
    bus.flush = 1'b0;
    bus.mem_ready = 1'b0;
    bus.mem_rdata = '0;
    resetModel();
    waitCycle();
    waitCycle();
    checkOutput("rst_stall", {31'h0, bus.stall}, 32'h0);
    checkOutput("rst_memReq", {31'h0, bus.mem_req}, 32'h0);
    checkOutput("rst_memWe", {31'h0, bus.mem_we}, 32'h0);
    checkOutput("rst_rdata", bus.rdata, 32'h0);
    checkCounters("rst");
    rst_n = 1'b1;
    waitCycle();

    $display("[TB] directed load/store sequence");
    memArr[30'h40] = 32'hDEADBEEF;
    runLoad("ld100miss", 32'h100, 2);
    runLoad("ld100hit", 32'h100, 0);
    runStore("st100hit", 32'h100, 32'h12345678, 1);
    runLoad("ld100afterSt", 32'h100, 0);
    runLoad("ld120evict", 32'h120, 1);
    runLoad("ld100evicted", 32'h100, 0);
    runStore("st140miss", 32'h140, 32'hCAFE0001, 0);
    runLoad("ld140noAlloc", 32'h140, 3);

    $display("[TB] random traffic");
    for (int n = 0; n < 150; n++) begin
      a = {tagPool[$urandom_range(0, 2)], 3'($urandom_range(0, 7)), 2'($urandom_range(0, 3))};
      if ($urandom_range(0, 9) == 0) pulseFlush();
      if ($urandom_range(0, 2) == 0) runStore("rndSt", a, $urandom, $urandom_range(0, 3));
      else runLoad("rndLd", a, $urandom_range(0, 3));
    end

    $display("[TB] reset during refill");
    bus.req_valid = 1'b1;
    bus.req_we = 1'b0;
    bus.addr = 32'h2000;
    bus.mem_ready = 1'b0;
    waitCycle();
    #1;
    checkOutput("refill_memReq", {31'h0, bus.mem_req}, 32'h1);
    rst_n = 1'b0;
    #1;
    checkOutput("midRst_memReq", {31'h0, bus.mem_req}, 32'h0);
    resetModel();
    checkCounters("midRst");
    bus.req_valid = 1'b0;
    waitCycle();
    rst_n = 1'b1;
    runLoad("ld100afterRst", 32'h100, 1);
    runLoad("ld100hitAgain", 32'h100, 0);
    pulseFlush();
    runLoad("ld100afterFlush", 32'h100, 0);

    $display("[TB] hit counter saturation");
    k = 65535 - modelHit;
    bus.req_valid = 1'b1;
    bus.req_we = 1'b0;
    bus.addr = 32'h100;
    for (int i = 0; i < k; i++) waitCycle();
    modelHit = 65535;
    checkOutput("sat_hitCnt", {16'h0, bus.hit_cnt}, 32'h0000FFFF);
    checkOutput("sat_stall", {31'h0, bus.stall}, 32'h0);
    checkOutput("sat_rdata", bus.rdata, modelData[0]);
    waitCycle();
    checkOutput("satHold_hitCnt", {16'h0, bus.hit_cnt}, 32'h0000FFFF);
    checkOutput("satHold_missCnt", {16'h0, bus.miss_cnt}, modelMiss);
    bus.req_valid = 1'b0;
    waitCycle();

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule

// File: doc/dcache.md
DCACHE -- requirements
Module: dcache

Interface
REQ-001 clk  input  1  single clock; all state updates on rising edge.
REQ-002 rst_n  input  1  reset, asynchronous, active-low.
REQ-003 req_valid  input  1  word access request from control path (driven by cacheEn).
REQ-004 req_we  input  1  1 = store word, 0 = load word (driven by MemWrite).
REQ-005 addr  input  32  byte address from ALU; [1:0] ignored, [4:2] index, [31:5] tag.
REQ-006 wdata  input  32  store data.
REQ-007 flush  input  1  invalidate all lines.
REQ-008 rdata  output  32  load data to writeback mux.
REQ-009 stall  output  1  1 = request not complete this cycle; CPU holds PC and request inputs stable.
REQ-010 mem_req, mem_we  output  1 each  memory request / write strobe.
REQ-011 mem_addr  output  32  {addr[31:2],2'b00}; mem_wdata  output  32  store data.
REQ-012 mem_ready  input  1  memory completes the outstanding request this cycle; mem_rdata  input  32  read data, valid with mem_ready.
REQ-013 hit_cnt, miss_cnt  output  16 each  load hit/miss counters.

Function
REQ-014 Direct-mapped, 8 lines, 1 word/line, per-line valid bit + 27-bit tag; write-through, no-write-allocate.
REQ-015 FSM states IDLE, REFILL, WRITE; reset state IDLE.
REQ-016 hit = valid[addr[4:2]] && tag[addr[4:2]] == addr[31:5], combinational.
REQ-017 IDLE, req_valid=0: stall=0, mem_req=0, no state change.
REQ-018 IDLE, load hit: rdata = line data same cycle, stall=0, stay IDLE, hit_cnt+1.
REQ-019 IDLE, load miss: stall=1, -> REFILL next edge, miss_cnt+1.
REQ-020 REFILL: mem_req=1, mem_we=0, stall=1; on mem_ready edge write mem_rdata, tag, valid=1 into line, -> IDLE; following cycle completes as hit (counted in hit_cnt).
REQ-021 IDLE, store: stall=1, -> WRITE next edge; if hit, line data updated with wdata at that edge; if miss, no line change.
REQ-022 WRITE: mem_req=1, mem_we=1, mem_wdata=wdata, stall = !mem_ready; on mem_ready edge -> IDLE.
REQ-023 mem_addr/mem_we/mem_wdata stable while mem_req=1; mem_ready ignored when mem_req=0.
REQ-024 Minimum latency: load hit 0 stall cycles; load miss N+2 stall-inclusive cycles for N-cycle memory wait (mem_ready on first REFILL cycle = N=0); store N+1.
REQ-025 flush: clears all valid bits at next edge in any state; same-edge refill is discarded (flush wins); FSM transitions unaffected.
REQ-026 Counters saturate at 16'hFFFF; only loads counted, stores never.
REQ-027 rdata = 32'h0 when not a completing load hit.

Reset
REQ-028 rst_n low: state IDLE, all valid=0, hit_cnt=miss_cnt=0, mem_req=0, mem_we=0, stall=0 (while req_valid=0); tag/data arrays not reset.
REQ-029 Reset asserted mid-REFILL or mid-WRITE aborts the transaction immediately; mem_req drops asynchronously; no line written.

Structure
REQ-030 Package cache_pkg holds state enum, INDEX_BITS=3, TAG_BITS=27, LINES=8, CNT_W=16.
REQ-031 One sub-module dcache_array: valid/tag/data storage, one write port, combinational read, flush and reset clear of valid.

Verification
REQ-032 Reset, load 0x100 with mem_ready after 2 cycles returning 0xDEADBEEF -> stall 4 cycles, then rdata=0xDEADBEEF, miss_cnt=1, hit_cnt=1.
REQ-033 Repeat load 0x100 -> stall=0, rdata=0xDEADBEEF, hit_cnt=2.
REQ-034 Store 0x12345678 to 0x100 (hit), mem_ready after 1 cycle -> mem_we=1, mem_addr=0x100, then load 0x100 hits with 0x12345678.
REQ-035 Load 0x120 (same index, different tag) after 0x100 cached -> miss, refill evicts; load 0x100 misses again.
REQ-036 Assert rst_n low during REFILL -> mem_req=0 immediately, subsequent load 0x100 misses; flush pulse then load -> miss.
REQ-037 Force hit_cnt to 0xFFFF via 65535 hits, one more hit -> stays 0xFFFF.
